// File: rtl/alu_cmd_issue.sv
// alu_cmd_issue: command FIFO feeding a registered ALU issue stage,
// with result capture, accumulator forwarding and a completion counter.
module alu_cmd_issue #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [3:0] cmd_A,
  input  logic [3:0] cmd_B,
  input  logic [1:0] cmd_op,
  input  logic       cmd_acc,
  input  logic       acc_clear,
  output logic [3:0] A,
  output logic [3:0] B,
  output logic [1:0] op_sel,
  input  logic [3:0] result,
  input  logic       flag,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [3:0] res_data,
  output logic       res_flag,
  output logic [3:0] acc,
  output logic [7:0] ops_done
);

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

  // entry layout: {acc_mode, op, B, A}
  logic [10:0]       mem [DEPTH];
  logic [ADDR_W-1:0] wp;
  logic [ADDR_W-1:0] rp;
  logic [ADDR_W:0]   cnt;
  logic              full;
  logic              empty;
  logic              push;
  logic              pop;
  logic              iss_valid;
  logic              out_adv;
  logic              iss_adv;
  logic              capture;
  logic [10:0]       head;
  logic [3:0]        a_next;

  assign full      = cnt == FULL_CNT;
  assign empty     = cnt == '0;
  assign cmd_ready = !full;
  assign push      = cmd_valid && !full;
  assign out_adv   = !res_valid || res_ready;
  assign iss_adv   = !iss_valid || out_adv;
  assign pop       = !empty && iss_adv;
  assign capture   = iss_valid && out_adv;
  assign head      = mem[rp];

  // acc-mode operand: clear wins, then the in-flight result, then acc
  always_comb begin
    a_next = head[3:0];
    if (head[10]) begin
      if (acc_clear)    a_next = '0;
      else if (capture) a_next = result;
      else              a_next = acc;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wp] <= {cmd_acc, cmd_op, cmd_B, cmd_A};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop)  rp <= rp + 1'b1;
      if (push && !pop)      cnt <= cnt + 1'b1;
      else if (pop && !push) cnt <= cnt - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      iss_valid <= 1'b0;
      A         <= '0;
      B         <= '0;
      op_sel    <= '0;
    end else begin
      if (pop) begin
        iss_valid <= 1'b1;
        A         <= a_next;
        B         <= head[7:4];
        op_sel    <= head[9:8];
      end else if (out_adv) begin
        iss_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_valid <= 1'b0;
      res_data  <= '0;
      res_flag  <= 1'b0;
      ops_done  <= '0;
    end else begin
      if (capture) begin
        res_valid <= 1'b1;
        res_data  <= result;
        res_flag  <= flag;
        ops_done  <= ops_done + 8'd1;
      end else if (res_valid && res_ready) begin
        res_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)            acc <= '0;
    else if (acc_clear) acc <= '0;
    else if (capture)   acc <= result;
  end

endmodule

// File: tb/tb_alu_cmd_issue.sv
// Bench for alu_cmd_issue: ALU environment model, in-order result
// scoreboard, directed scenarios and a randomized traffic phase.
module tb_alu_cmd_issue;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [3:0] cmd_A = '0;
  logic [3:0] cmd_B = '0;
  logic [1:0] cmd_op = '0;
  logic       cmd_acc = 1'b0;
  logic       acc_clear = 1'b0;
  logic [3:0] A;
  logic [3:0] B;
  logic [1:0] op_sel;
  logic [3:0] result;
  logic       flag;
  logic       res_valid;
  logic       res_ready = 1'b1;
  logic [3:0] res_data;
  logic       res_flag;
  logic [3:0] acc;
  logic [7:0] ops_done;

  always #5 clk = ~clk;

  alu_cmd_issue #(.DEPTH(4), .ADDR_W(2)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_A(cmd_A), .cmd_B(cmd_B), .cmd_op(cmd_op), .cmd_acc(cmd_acc),
    .acc_clear(acc_clear),
    .A(A), .B(B), .op_sel(op_sel),
    .result(result), .flag(flag),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_flag(res_flag),
    .acc(acc), .ops_done(ops_done)
  );

  function automatic logic [4:0] alu_ref(input logic [3:0] a,
                                         input logic [3:0] b,
                                         input logic [1:0] op);
    case (op)
      2'b00:   return {1'b0, a} + {1'b0, b};
      2'b01:   return {(a < b), 4'(a - b)};
      2'b10:   return {1'b0, a & b};
      default: return {1'b0, a | b};
    endcase
  endfunction

  assign {flag, result} = alu_ref(A, B, op_sel);

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // scoreboard: expected {flag,data} in command order
  logic [4:0] expq[$];
  logic [4:0] obs[$];
  int         obs_cyc[$];
  int         n_acc = 0;
  int         n_out = 0;
  int         cyc = 0;
  logic [3:0] macc = '0;
  logic [3:0] m_a;
  logic [4:0] m_e;
  bit         mon_en = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic model_clear();
    expq.delete();
    obs.delete();
    obs_cyc.delete();
    n_acc = 0;
    n_out = 0;
    macc  = '0;
  endtask

  always @(negedge clk) begin
    if (!rst && mon_en) begin
      chk("ops_done", int'(ops_done), (n_out + int'(res_valid)) % 256);
      if (res_valid) chk("acc_tracks_result", int'(acc), int'(res_data));
      if (n_acc - n_out > 6) chk("inflight_bound", n_acc - n_out, 6);
      if (n_acc - n_out == 6) chk("full_not_ready", int'(cmd_ready), 0);
      if (cmd_valid && cmd_ready) begin
        m_a  = cmd_acc ? macc : cmd_A;
        m_e  = alu_ref(m_a, cmd_B, cmd_op);
        macc = m_e[3:0];
        expq.push_back(m_e);
        n_acc++;
      end
      if (res_valid && res_ready) begin
        if (expq.size() == 0) begin
          chk("unexpected_result", 1, 0);
        end else begin
          m_e = expq.pop_front();
          chk("res_data", int'(res_data), int'(m_e[3:0]));
          chk("res_flag", int'(res_flag), int'(m_e[4]));
        end
        obs.push_back({res_flag, res_data});
        obs_cyc.push_back(cyc);
        n_out++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic push_cmd(input logic [3:0] a, input logic [3:0] b,
                          input logic [1:0] op, input logic am);
    bit done;
    done      = 1'b0;
    cmd_valid = 1'b1;
    cmd_A     = a;
    cmd_B     = b;
    cmd_op    = op;
    cmd_acc   = am;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      done = cmd_ready;
      tick();
    end
    cmd_valid = 1'b0;
    if (!done) chk("push_timeout", 0, 1);
  endtask

  task automatic flood(input int n);
    cmd_valid = 1'b1;
    for (int i = 0; i < n; i++) begin
      cmd_A   = 4'($urandom);
      cmd_B   = 4'($urandom);
      cmd_op  = 2'($urandom);
      cmd_acc = 1'($urandom);
      tick();
    end
    cmd_valid = 1'b0;
  endtask

  int base;
  int acc_base;
  int out_base;

  initial begin
    do_reset();
    chk("rst_cmd_ready", int'(cmd_ready), 1);
    chk("rst_res_valid", int'(res_valid), 0);
    chk("rst_A", int'(A), 0);
    chk("rst_B", int'(B), 0);
    chk("rst_op_sel", int'(op_sel), 0);
    chk("rst_res_data", int'(res_data), 0);
    chk("rst_res_flag", int'(res_flag), 0);
    chk("rst_acc", int'(acc), 0);
    chk("rst_ops_done", int'(ops_done), 0);

    // single add latency
    res_ready = 1'b1;
    push_cmd(4'd9, 4'd8, 2'b00, 1'b0);
    tick();
    chk("add_A", int'(A), 9);
    chk("add_B", int'(B), 8);
    chk("add_op", int'(op_sel), 0);
    chk("add_not_yet", int'(res_valid), 0);
    tick();
    chk("add_valid", int'(res_valid), 1);
    chk("add_data", int'(res_data), 1);
    chk("add_flag", int'(res_flag), 1);
    chk("add_acc", int'(acc), 1);
    chk("add_ops", int'(ops_done), 1);
    repeat (3) tick();

    // accumulate chain with forwarding
    base = obs.size();
    push_cmd(4'd3, 4'd2, 2'b00, 1'b0);
    push_cmd(4'd0, 4'd4, 2'b00, 1'b1);
    push_cmd(4'd0, 4'd1, 2'b01, 1'b1);
    chk("fwd_A", int'(A), 5);
    chk("fwd_B", int'(B), 4);
    repeat (5) tick();
    if (obs.size() < base + 3) begin
      chk("chain_count", obs.size() - base, 3);
    end else begin
      chk("chain_r0", int'(obs[base]), 5);
      chk("chain_r1", int'(obs[base+1]), 9);
      chk("chain_r2", int'(obs[base+2]), 8);
      chk("chain_gap1", obs_cyc[base+1] - obs_cyc[base], 1);
      chk("chain_gap2", obs_cyc[base+2] - obs_cyc[base+1], 1);
    end

    // borrow and logic ops
    base = obs.size();
    push_cmd(4'd2, 4'd5, 2'b01, 1'b0);
    push_cmd(4'd12, 4'd10, 2'b10, 1'b0);
    push_cmd(4'd12, 4'd3, 2'b11, 1'b0);
    repeat (5) tick();
    if (obs.size() < base + 3) begin
      chk("logic_count", obs.size() - base, 3);
    end else begin
      chk("sub_borrow", int'(obs[base]), 5'h1D);
      chk("and_res", int'(obs[base+1]), 8);
      chk("or_res", int'(obs[base+2]), 15);
    end

    // backpressure
    res_ready = 1'b0;
    acc_base  = n_acc;
    out_base  = n_out;
    flood(12);
    chk("bp_accepted", n_acc - acc_base, 6);
    chk("bp_ready_low", int'(cmd_ready), 0);
    chk("bp_res_valid", int'(res_valid), 1);
    res_ready = 1'b1;
    repeat (10) tick();
    chk("bp_drained", n_out - out_base, 6);
    chk("bp_queue_empty", expq.size(), 0);

    // reset mid-stream
    res_ready = 1'b0;
    flood(12);
    chk("mid_res_valid_pre", int'(res_valid), 1);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("mid_res_valid", int'(res_valid), 0);
    chk("mid_cmd_ready", int'(cmd_ready), 1);
    chk("mid_acc", int'(acc), 0);
    chk("mid_ops_done", int'(ops_done), 0);
    chk("mid_A", int'(A), 0);
    model_clear();
    tick();
    rst = 1'b0;
    res_ready = 1'b1;
    repeat (10) tick();
    chk("mid_no_stale", n_out, 0);
    chk("mid_idle", int'(res_valid), 0);

    // acc_clear collisions
    mon_en = 1'b0;
    do_reset();
    push_cmd(4'd3, 4'd4, 2'b00, 1'b0);
    repeat (3) tick();
    chk("clr_acc7", int'(acc), 7);
    push_cmd(4'd0, 4'd1, 2'b00, 1'b1);
    acc_clear = 1'b1;
    tick();
    acc_clear = 1'b0;
    chk("clr_A0", int'(A), 0);
    chk("clr_B1", int'(B), 1);
    chk("clr_acc0", int'(acc), 0);
    tick();
    chk("clr_res1", int'(res_data), 1);
    chk("clr_acc1", int'(acc), 1);
    push_cmd(4'd5, 4'd1, 2'b00, 1'b0);
    tick();
    acc_clear = 1'b1;
    tick();
    acc_clear = 1'b0;
    chk("clrcap_res", int'(res_data), 6);
    chk("clrcap_valid", int'(res_valid), 1);
    chk("clrcap_acc", int'(acc), 0);
    chk("clrcap_ops", int'(ops_done), 3);

    // randomized traffic against the scoreboard
    do_reset();
    mon_en = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      cmd_valid = ($urandom_range(0, 3) != 0);
      cmd_A     = 4'($urandom);
      cmd_B     = 4'($urandom);
      cmd_op    = 2'($urandom);
      cmd_acc   = 1'($urandom);
      res_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    cmd_valid = 1'b0;
    res_ready = 1'b1;
    repeat (20) tick();
    chk("rand_queue_empty", expq.size(), 0);
    chk("rand_all_out", n_out, n_acc);
    chk("rand_ops_wrap", int'(ops_done), n_out % 256);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_cmd_issue.md
Name: alu_cmd_issue

Overview:
- Command front-end for the 4-bit combinational ALU: buffers operation requests, drives the ALU operands from a registered issue stage, and captures the ALU result and flag into a registered output with valid/ready handshake.
- Supports an accumulate mode where operand A is the previous result. This is the building block for multi-step nibble arithmetic in the datapath.
- Sits directly upstream of the ALU and also consumes its result.

Parameters:
- DEPTH, 4, command FIFO entries (power of 2, >=2)
- ADDR_W, 2, log2(DEPTH)

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- cmd_valid  input  1  command offered
- cmd_ready  output  1  FIFO can accept a command
- cmd_A  input  4  operand A (ignored when cmd_acc=1)
- cmd_B  input  4  operand B
- cmd_op  input  2  op select: 00 add, 01 sub, 10 and, 11 or
- cmd_acc  input  1  use accumulator as operand A
- acc_clear  input  1  synchronous accumulator clear
- A  output  4  to ALU operand A (registered)
- B  output  4  to ALU operand B (registered)
- op_sel  output  2  to ALU op select (registered)
- result  input  4  from ALU
- flag  input  1  from ALU carry/borrow
- res_valid  output  1  output register holds a result
- res_ready  input  1  downstream accepts result
- res_data  output  4  captured result
- res_flag  output  1  captured flag
- acc  output  4  accumulator value
- ops_done  output  8  completed-result counter

Behaviour:
- Reset (async, immediate):
  - FIFO empty, so cmd_ready=1.
  - Issue stage invalid; A, B, op_sel = 0.
  - res_valid=0, res_data=0, res_flag=0, acc=0, ops_done=0.
- FIFO:
  - Push when cmd_valid && cmd_ready; cmd_ready = !full.
  - cmd_ready does not depend on a same-cycle pop, so a full FIFO refuses input even if popping.
  - Pointers wrap modulo DEPTH; a separate count (0..DEPTH) gives full/empty.
  - Simultaneous push and pop when not full: count unchanged.
- Pipeline control:
  - out_adv = !res_valid || res_ready.
  - iss_adv = !iss_valid || out_adv.
  - Pop FIFO head into the issue stage when !empty && iss_adv.
  - iss_valid next = (pop) ? 1 : (out_adv ? 0 : iss_valid).
- Issue stage:
  - On pop, register A, B, op_sel from the head entry.
  - Operand A source when head cmd_acc=1:
    - If acc_clear is high this cycle: 0 (clear wins).
    - Else, if iss_valid && out_adv: forward the ALU result (the in-flight result).
    - Else: acc.
  - A, B, op_sel hold while the issue stage is stalled.
- Output capture:
  - When iss_valid && out_adv: res_data<=result, res_flag<=flag, res_valid<=1, acc<=result, ops_done<=ops_done+1 (8-bit wrap 255->0).
  - When res_valid && res_ready && !(iss_valid): res_valid<=0, data held.
- acc_clear: acc<=0 next edge, overriding a same-cycle capture into acc. Capture into res_data still occurs.
- Latency:
  - Command accepted at edge N into an empty pipe: A/B/op_sel valid after edge N+1, res_valid=1 after edge N+2.
  - Sustained throughput is 1 command/cycle with res_ready held high.
- Backpressure: with res_ready=0, the output holds, then the issue stage holds, then the FIFO fills and cmd_ready drops. No command is lost or duplicated.
- Flag pass-through: and/or ops produce flag=0 from the ALU; the flag is captured unchanged.
- Reset mid-operation: all in-flight and queued commands are discarded; outputs return to reset values asynchronously.

Test Plan:
- Single add: after reset, push A=9,B=8,op=00,acc=0 at edge N -> after N+1 A=9,B=8,op_sel=00; after N+2 res_valid=1, res_data=1, res_flag=1, acc=1, ops_done=1.
- Accumulate chain, back-to-back with res_ready=1: push (A=3,B=2,add), then (acc,B=4,add), then (acc,B=1,sub) -> results 5, 9, 8 on consecutive cycles with flags 0,0,0; the second command's A=5 comes via forwarding.
- Backpressure: res_ready=0, push 6 commands -> DEPTH+2=6 accepted (FIFO 4 + issue + output) and cmd_ready=0. Raise res_ready -> six results in order, none dropped.
- Borrow/logic: push A=2,B=5,sub; A=12,B=10,and; A=12,B=3,or -> (13, flag 1), (8, flag 0), (15, flag 0).
- acc_clear collision: acc=7, issue an acc-mode add B=1 in the same cycle as acc_clear -> A driven 0, result 1. A separate capture coinciding with acc_clear leaves acc=0.
- Reset mid-stream: assert rst with 3 queued commands and res_valid=1 -> immediately res_valid=0, cmd_ready=1, acc=0, ops_done=0. No stale result appears after release.
